// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Brief  : Shared constants and next-count helper for the param_counter family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam int MAX_WIDTH = 32;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] q;
    logic                 wrapped;
  } next_t;

  // Modulus is one bit wider than the count so that 2**MAX_WIDTH is representable.
  function automatic next_t next_count(
    input logic [MAX_WIDTH-1:0] q,
    input logic                 up,
    input logic [MAX_WIDTH:0]   modulus,
    input logic                 saturate
  );
    next_t                r;
    logic [MAX_WIDTH-1:0] last_q;
    logic [MAX_WIDTH:0]   last_ext;
    last_ext  = modulus - (MAX_WIDTH+1)'(1);
    last_q    = modulus[MAX_WIDTH-1:0] - MAX_WIDTH'(1);
    r.q       = q;
    r.wrapped = 1'b0;
    if (up) begin
      if ({1'b0, q} < last_ext) begin
        r.q = q + MAX_WIDTH'(1);
      end else if (!saturate) begin
        r.q       = '0;
        r.wrapped = 1'b1;
      end
    end else begin
      if (q != '0) begin
        r.q = q - MAX_WIDTH'(1);
      end else if (!saturate) begin
        r.q       = last_q;
        r.wrapped = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_tc_dec.sv
// ============================================================================
// Module : counter_tc_dec
// Brief  : Terminal-count and cascade-carry decode for modulo up/down counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_tc_dec
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = longint'(1) << WIDTH
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  input  logic             ctt_i,
  output logic             tc_o,
  output logic             co_o
);

  localparam logic [MAX_WIDTH:0] LAST = MODULUS[MAX_WIDTH:0] - (MAX_WIDTH+1)'(1);

  // Up-count uses >= so out-of-range loaded values still flag terminal count.
  assign tc_o = (up_i && ((MAX_WIDTH+1)'(q_i) >= LAST)) || (!up_i && (q_i == '0));
  assign co_o = tc_o & ctt_i;

endmodule

`default_nettype wire

// File: rtl/param_counter.sv
// ============================================================================
// Module : param_counter
// Brief  : Presettable modulo-N up/down counter with wrap/saturate, TC/CO and
//          registered wrap pulse. Define PARAM_COUNTER_SCLR_EN to add SCLRn.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module param_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = longint'(1) << WIDTH,
  parameter int     SATURATE = 0
) (
  input  logic             CP,
  input  logic             CRn,
`ifdef PARAM_COUNTER_SCLR_EN
  input  logic             SCLRn,
`endif
  input  logic             LDn,
  input  logic [WIDTH-1:0] D,
  input  logic             CTT,
  input  logic             CTP,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO,
  output logic             WRAP
);

  localparam logic [MAX_WIDTH:0] MOD_EXT = MODULUS[MAX_WIDTH:0];
  localparam logic               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             sclr;
  next_t            nxt;

`ifdef PARAM_COUNTER_SCLR_EN
  assign sclr = ~SCLRn;
`else
  assign sclr = 1'b0;
`endif

  assign nxt = next_count(MAX_WIDTH'(q_q), UP, MOD_EXT, SAT);

  generate
    if (WIDTH < MAX_WIDTH) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = |nxt.q[MAX_WIDTH-1:WIDTH];
    end
  endgenerate

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (sclr) begin
      q_d = '0;
    end else if (!LDn) begin
      q_d = D;
    end else if (CTT && CTP) begin
      q_d    = nxt.q[WIDTH-1:0];
      wrap_d = nxt.wrapped;
    end
  end

  always_ff @(posedge CP or negedge CRn) begin
    if (!CRn) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;

  counter_tc_dec #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc_dec (
    .q_i   (q_q),
    .up_i  (UP),
    .ctt_i (CTT),
    .tc_o  (TC),
    .co_o  (CO)
  );

endmodule

`default_nettype wire

// File: tb/tb_param_counter.sv
// ============================================================================
// Module : tb_param_counter
// Brief  : Directed self-checking bench for param_counter (default, mod-10,
//          saturating and cascaded configurations).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_counter;

  logic cp = 1'b0;
  always #5 cp = ~cp;

  logic       crn, ldn, ctt, ctp, up;
  logic [3:0] d;
`ifdef PARAM_COUNTER_SCLR_EN
  logic       sclrn;
`endif

  logic [3:0] q0, qm, qs;
  logic       tc0, co0, w0, tcm, com, wm, tcs, cos, ws;

  logic       ccrn, cctp;
  logic [3:0] qlo, qhi;
  logic       tclo, colo, wlo, tchi, cohi, whi;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  param_counter u_def (
    .CP(cp), .CRn(crn),
`ifdef PARAM_COUNTER_SCLR_EN
    .SCLRn(sclrn),
`endif
    .LDn(ldn), .D(d), .CTT(ctt), .CTP(ctp), .UP(up),
    .Q(q0), .TC(tc0), .CO(co0), .WRAP(w0)
  );

  param_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .CP(cp), .CRn(crn),
`ifdef PARAM_COUNTER_SCLR_EN
    .SCLRn(sclrn),
`endif
    .LDn(ldn), .D(d), .CTT(ctt), .CTP(ctp), .UP(up),
    .Q(qm), .TC(tcm), .CO(com), .WRAP(wm)
  );

  param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
    .CP(cp), .CRn(crn),
`ifdef PARAM_COUNTER_SCLR_EN
    .SCLRn(sclrn),
`endif
    .LDn(ldn), .D(d), .CTT(ctt), .CTP(ctp), .UP(up),
    .Q(qs), .TC(tcs), .CO(cos), .WRAP(ws)
  );

  param_counter u_lo (
    .CP(cp), .CRn(ccrn),
`ifdef PARAM_COUNTER_SCLR_EN
    .SCLRn(1'b1),
`endif
    .LDn(1'b1), .D(4'h0), .CTT(1'b1), .CTP(cctp), .UP(1'b1),
    .Q(qlo), .TC(tclo), .CO(colo), .WRAP(wlo)
  );

  param_counter u_hi (
    .CP(cp), .CRn(ccrn),
`ifdef PARAM_COUNTER_SCLR_EN
    .SCLRn(1'b1),
`endif
    .LDn(1'b1), .D(4'h0), .CTT(colo), .CTP(cctp), .UP(1'b1),
    .Q(qhi), .TC(tchi), .CO(cohi), .WRAP(whi)
  );

  initial begin
    crn = 1'b0; ldn = 1'b1; ctt = 1'b0; ctp = 1'b0; up = 1'b1; d = 4'h0;
    ccrn = 1'b0; cctp = 1'b0;
`ifdef PARAM_COUNTER_SCLR_EN
    sclrn = 1'b1;
`endif
    #12;
    check("rst_q",    32'(q0),  0);
    check("rst_wrap", 32'(w0),  0);
    check("rst_tc_up", 32'(tc0), 0);
    up = 1'b0; #1;
    check("rst_tc_dn", 32'(tc0), 1);
    check("rst_co_ctt0", 32'(co0), 0);
    ctt = 1'b1; #1;
    check("rst_co_ctt1", 32'(co0), 1);
    up = 1'b1; ctp = 1'b1; crn = 1'b1;

    // Free-running binary count with natural wrap
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("up_q", 32'(q0), 32'(i));
      check("up_wrap", 32'(w0), 0);
    end
    check("up_tc15", 32'(tc0), 1);
    check("up_co15", 32'(co0), 1);
    tick();
    check("up_wrap_q", 32'(q0), 0);
    check("up_wrap_pulse", 32'(w0), 1);
    tick();
    check("up_after_q", 32'(q0), 1);
    check("up_after_wrap", 32'(w0), 0);

    // Load beats count; CTP gates counting but not CO
    ldn = 1'b0; d = 4'd5; tick();
    check("ld_wins", 32'(q0), 5);
    d = 4'd15; tick();
    check("ld_15", 32'(q0), 15);
    check("ld_no_wrap", 32'(w0), 0);
    ldn = 1'b1; ctp = 1'b0; tick();
    check("ctp0_hold", 32'(q0), 15);
    check("ctp0_co", 32'(co0), 1);
    ctt = 1'b0; #1;
    check("ctt0_co", 32'(co0), 0);
    check("ctt0_tc", 32'(tc0), 1);

    // Modulo-10 down count
    up = 1'b0; ctt = 1'b1; ctp = 1'b1; ldn = 1'b0; d = 4'd0; tick();
    check("m10_ld0", 32'(qm), 0);
    check("m10_tc0", 32'(tcm), 1);
    ldn = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      check("m10_dn_q", 32'(qm), (i < 10) ? 32'(9 - i) : 32'd9);
      if (i == 0 || i == 10) check("m10_dn_wrap", 32'(wm), 1);
      if (i == 9) check("m10_dn_tc", 32'(tcm), 1);
    end
    ldn = 1'b0; d = 4'd12; tick();
    check("m10_ld12", 32'(qm), 12);
    ldn = 1'b1; tick();
    check("m10_dn_from12", 32'(qm), 11);
    check("m10_dn12_wrap", 32'(wm), 0);

    // Saturating up count from 8, modulo-10 alongside wraps
    up = 1'b1; ldn = 1'b0; d = 4'd8; tick();
    check("sat_ld8", 32'(qs), 8);
    ldn = 1'b1; tick();
    check("sat_q9", 32'(qs), 9);
    check("sat_tc9", 32'(tcs), 1);
    check("m10_q9", 32'(qm), 9);
    tick();
    check("sat_hold1", 32'(qs), 9);
    check("sat_nowrap1", 32'(ws), 0);
    check("m10_up_wrap_q", 32'(qm), 0);
    check("m10_up_wrap", 32'(wm), 1);
    tick();
    check("sat_hold2", 32'(qs), 9);
    check("sat_nowrap2", 32'(ws), 0);
    check("sat_tc_hold", 32'(tcs), 1);
    check("m10_q1", 32'(qm), 1);
    up = 1'b0; ldn = 1'b0; d = 4'd0; tick();
    ldn = 1'b1; tick();
    check("sat_dn_hold", 32'(qs), 0);
    check("sat_dn_nowrap", 32'(ws), 0);

    // Asynchronous clear between edges
    up = 1'b1; ldn = 1'b0; d = 4'd7; tick();
    ldn = 1'b1; ctt = 1'b0;
    #3; crn = 1'b0; #1;
    check("async_clr_q", 32'(q0), 0);
    check("async_clr_wrap", 32'(w0), 0);
    crn = 1'b1; ctt = 1'b1; tick();
    check("resume_q", 32'(q0), 1);
    ldn = 1'b0; d = 4'd15; tick();
    ldn = 1'b1; tick();
    check("pre_clr_wrap", 32'(w0), 1);
    #2; crn = 1'b0; #1;
    check("async_clr_wrap1", 32'(w0), 0);
    crn = 1'b1;
`ifdef PARAM_COUNTER_SCLR_EN
    ldn = 1'b0; d = 4'd9; tick();
    sclrn = 1'b0; tick();
    check("sclr_over_ld", 32'(q0), 0);
    check("sclr_wrap", 32'(w0), 0);
    sclrn = 1'b1; ldn = 1'b1;
`endif

    // Two-stage cascade forms an 8-bit counter
    ccrn = 1'b1; cctp = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      check("cascade", 32'({qhi, qlo}), 32'(i & 255));
    end
    check("cascade_hi_wrap", 32'(whi), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
